// File: rtl/bram_reader_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bram_reader_pkg
// Description : Shared types and width helpers for the BRAM stream reader.
//               - state_t    : reader FSM states (IDLE, RUN, DRAIN)
//               - FIFO_DEPTH : depth of the output skid FIFO
//               - CNT_W      : width of the FIFO occupancy count
//               - addr_w/len_w/data_w : port widths derived from DEPTH/WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
package bram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;

  // RAM address width for a given DEPTH setting.
  function automatic int addr_w(input int depth);
    return 12 + depth;
  endfunction

  // Word-count width: one bit wider than the address so that a full sweep
  // of the RAM (2^addr_w words) is representable.
  function automatic int len_w(input int depth);
    return 13 + depth;
  endfunction

  // RAM word width for a given WIDTH setting.
  function automatic int data_w(input int width);
    return 8 << width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_skid_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bram_skid_fifo
// Description : 2-entry synchronous FIFO absorbing the RAM read latency so the
//               stream can stall without losing words. The head entry is a
//               plain register, so head data is stable until popped.
// Ports       : clk, rst_n (async, active-low)
//               flush      - empties the FIFO (wins over push/pop)
//               push/push_data - write one word
//               pop        - remove the head word (only when count != 0)
//               count      - current occupancy (0..2)
//               head       - head word
// Revision    : 1.0 - initial release
// ============================================================================
module bram_skid_fifo
  import bram_reader_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_data0;  // head slot
  logic [DATA_W-1:0] r_data1;  // second slot

  // Shift-register organisation: entries always advance toward slot 0, so
  // the head is read directly from r_data0 without a read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (r_count == '0) begin
            r_data0 <= push_data;
          end else begin
            r_data1 <= push_data;
          end
          if (r_count < CNT_W'(FIFO_DEPTH)) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_count <= r_count - CNT_W'(1);
        end
        2'b11: begin
          // Occupancy unchanged; head advances and the new word lands behind it.
          if (r_count == CNT_W'(1)) begin
            r_data0 <= push_data;
          end else begin
            r_data0 <= r_data1;
            r_data1 <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count = r_count;
  assign head  = r_data0;

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bram_stream_reader
// Description : Sequential read engine on the read port of a block RAM with a
//               fixed one-cycle read latency. Streams length words starting at
//               start_addr as a valid/ready stream, one word per clock, with
//               lossless backpressure through a 2-entry output FIFO.
// Ports       : clk, rst_n (async, active-low)
//               start, start_addr, length - transfer request (IDLE only)
//               abort      - cancel at once, no done pulse
//               busy, done - status; done pulses one cycle after last pop
//               raddr, rval - RAM read address / read data
//               out_data, out_valid, out_ready - output stream
//               loop       - restart the pass seamlessly at its end
//                            (only with BRAM_READER_LOOP_EN defined)
// Config      : BRAM_READER_LOOP_EN - adds the loop input and looping.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int WIDTH = 0,
  parameter int DEPTH = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [addr_w(DEPTH)-1:0]    start_addr,
  input  logic [len_w(DEPTH)-1:0]     length,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic [addr_w(DEPTH)-1:0]    raddr,
  input  logic [data_w(WIDTH)-1:0]    rval,
  output logic [data_w(WIDTH)-1:0]    out_data,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef BRAM_READER_LOOP_EN
  ,
  input  logic                        loop
`endif
);

  localparam int AW = addr_w(DEPTH);
  localparam int LW = len_w(DEPTH);
  localparam int DW = data_w(WIDTH);

  state_t            r_state;
  logic [AW-1:0]     r_addr;
  logic [LW-1:0]     r_remaining;
  logic              r_inflight;
  logic              r_busy;
  logic              r_done;
`ifdef BRAM_READER_LOOP_EN
  logic [AW-1:0]     r_start_addr;
  logic [LW-1:0]     r_length;
`endif

  logic [CNT_W-1:0]  w_count;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_credit;

  // --------------------------------------------------------------------------
  // Output FIFO. Every word issued to the RAM arrives one cycle later while
  // r_inflight is set; that is the only time rval is captured.
  // --------------------------------------------------------------------------
  bram_skid_fifo #(
    .DATA_W (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (r_inflight),
    .push_data (rval),
    .pop       (w_pop),
    .count     (w_count),
    .head      (out_data)
  );

  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid & out_ready;

  // Words already committed (buffered + in flight) after this cycle's pop.
  // Allowing an issue only when at most one is committed guarantees the new
  // word has a free slot when it arrives, while still sustaining 1 word/clk.
  assign w_credit = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue  = (r_state == ST_RUN) && !abort && (w_credit <= 3'd1);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_inflight   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef BRAM_READER_LOOP_EN
      r_start_addr <= '0;
      r_length     <= '0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (length != '0) begin
                r_addr       <= start_addr;
                r_remaining  <= length;
                r_state      <= ST_RUN;
                r_busy       <= 1'b1;
`ifdef BRAM_READER_LOOP_EN
                r_start_addr <= start_addr;
                r_length     <= length;
`endif
              end else begin
                // Empty transfer completes immediately without going busy.
                r_done <= 1'b1;
              end
            end
          end

          ST_RUN: begin
            if (w_issue) begin
              r_addr      <= r_addr + AW'(1);
              r_remaining <= r_remaining - LW'(1);
              if (r_remaining == LW'(1)) begin
`ifdef BRAM_READER_LOOP_EN
                // Reload on the final issue so the next pass's first address
                // goes out on the very next cycle: no bubble at the seam.
                if (loop) begin
                  r_addr      <= r_start_addr;
                  r_remaining <= r_length;
                end else
`endif
                r_state <= ST_DRAIN;
              end
            end
          end

          ST_DRAIN: begin
            if ((w_count == '0) && !r_inflight && !w_pop) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign raddr = r_addr;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Self-checking bench for bram_stream_reader (WIDTH=0, DEPTH=1).
//               A behavioural RAM with one-cycle read latency feeds the DUT;
//               a queue of expected words is built from start address, length
//               and the RAM contents, and compared against accepted beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

  localparam int NWORDS = 8192;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] start_addr;
  logic [13:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic [12:0] raddr;
  logic [7:0]  rval;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef BRAM_READER_LOOP_EN
  logic        loop;
`endif

  logic [7:0]  mem [0:NWORDS-1];

  int checks;
  int failures;

  bram_stream_reader #(
    .WIDTH (0),
    .DEPTH (1)
  ) dut (
`ifdef BRAM_READER_LOOP_EN
    .loop       (loop),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .rval       (rval),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read port: data for the address sampled at an edge appears after it.
  always @(posedge clk) rval <= mem[raddr];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transfer. mode: 0 = ready always high, 1 = random ready,
  // 2 = ready pattern 1,0,0 repeating. restart pulses an illegal start mid-run.
  task automatic do_xfer(input int sa, input int len, input int mode, input bit restart);
    logic [7:0] q[$];
    logic [7:0] prev_data;
    logic [7:0] exp_w;
    int  cyc, last_pop, first_valid, budget;
    bit  done_seen, prev_stall;
    for (int i = 0; i < len; i++) q.push_back(mem[(sa + i) % NWORDS]);
    @(negedge clk);
    start      = 1'b1;
    start_addr = 13'(sa);
    length     = 14'(len);
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    if (len == 0) begin
      chk_eq("zlen_done", done, 1);
      chk_eq("zlen_busy", busy, 0);
      chk_eq("zlen_valid", out_valid, 0);
      @(negedge clk);
      chk_eq("zlen_done_once", done, 0);
      chk_eq("zlen_busy2", busy, 0);
      chk_eq("zlen_valid2", out_valid, 0);
      return;
    end
    budget      = len * 4 + 40;
    done_seen   = 1'b0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    first_valid = -1;
    last_pop    = -1;
    while (!done_seen && cyc < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc % 3 == 0);
      endcase
      if (prev_stall) begin
        chk_eq("hold_valid", out_valid, 1);
        chk_eq("hold_data", out_data, prev_data);
      end
      if (done) begin
        done_seen = 1'b1;
        chk_eq("done_words_left", q.size(), 0);
        chk_eq("done_timing", cyc, last_pop + 2);
        chk_eq("done_busy", busy, 0);
        chk_eq("done_valid", out_valid, 0);
      end else begin
        chk_eq("busy_run", busy, 1);
        if (out_valid && first_valid < 0) begin
          first_valid = cyc;
          chk_eq("latency", cyc, 3);
        end
        if (out_valid && out_ready) begin
          chk_eq("word_expected", (q.size() > 0), 1);
          if (q.size() > 0) begin
            exp_w = q.pop_front();
            chk_eq("data", out_data, exp_w);
          end
          last_pop = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (restart) begin
        start = (cyc == 4) && (len >= 3);
        if (start) begin
          start_addr = 13'($urandom);
          length     = 14'($urandom_range(1, 50));
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk_eq("xfer_completed", done_seen, 1);
    chk_eq("done_one_cycle", done, 0);
  endtask

  // Stop a transfer with 2 words buffered, by abort or by async reset.
  task automatic abort_test(input bit use_reset);
    @(negedge clk);
    start      = 1'b1;
    start_addr = 13'($urandom);
    length     = 14'd10;
    out_ready  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk_eq("abort_pre_valid", out_valid, 1);
    chk_eq("abort_pre_busy", busy, 1);
    if (!use_reset) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end else begin
      rst_n = 1'b0;
      #1;
      chk_eq("rst_mid_raddr", raddr, 0);
      chk_eq("rst_mid_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    chk_eq("abort_valid", out_valid, 0);
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_done", done, 0);
    repeat (4) begin
      @(negedge clk);
      chk_eq("abort_no_done", done, 0);
      chk_eq("abort_idle_valid", out_valid, 0);
    end
    do_xfer($urandom_range(0, NWORDS - 1), 6, 1, 1'b0);
  endtask

`ifdef BRAM_READER_LOOP_EN
  task automatic loop_test(input int sa);
    int  n, cyc;
    bit  seen, done_seen;
    @(negedge clk);
    loop       = 1'b1;
    out_ready  = 1'b1;
    start      = 1'b1;
    start_addr = 13'(sa);
    length     = 14'd3;
    @(negedge clk);
    start     = 1'b0;
    n         = 0;
    cyc       = 1;
    seen      = 1'b0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 200) begin
      if (done) begin
        done_seen = 1'b1;
        chk_eq("loop_whole_passes", n % 3, 0);
        chk_eq("loop_min_words", (n >= 9), 1);
      end else begin
        if (n < 9) chk_eq("loop_no_done", done, 0);
        if (seen && n < 9) chk_eq("loop_no_bubble", out_valid, 1);
        if (out_valid) begin
          seen = 1'b1;
          chk_eq("loop_data", out_data, mem[(sa + (n % 3)) % NWORDS]);
          n++;
          if (n == 9) loop = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk_eq("loop_completed", done_seen, 1);
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    abort      = 1'b0;
    out_ready  = 1'b0;
`ifdef BRAM_READER_LOOP_EN
    loop       = 1'b0;
`endif
    for (int i = 0; i < NWORDS; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_valid", out_valid, 0);
    chk_eq("rst_raddr", raddr, 0);
    chk_eq("rst_data", out_data, 0);
    rst_n = 1'b1;

    do_xfer(5, 4, 0, 1'b0);
    do_xfer(5, 4, 2, 1'b0);
    do_xfer(13'h1FFE, 4, 0, 1'b0);
    do_xfer(13'h1FFF, 1, 1, 1'b0);
    do_xfer(0, 0, 0, 1'b0);
    abort_test(1'b0);
    abort_test(1'b1);
    for (int t = 0; t < 14; t++) begin
      do_xfer($urandom_range(0, NWORDS - 1), $urandom_range(1, 24),
              $urandom_range(0, 2), 1'b1);
    end
    do_xfer(100, NWORDS, 0, 1'b0);
`ifdef BRAM_READER_LOOP_EN
    loop_test($urandom_range(0, NWORDS - 1));
    loop_test(13'h1FFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
